// File: rtl/data_mem_lsu.sv
// Word-addressed data memory with an RV32I load/store unit; zeroes itself after reset.
// One request per cycle, responses registered one cycle after acceptance.
module data_mem_lsu #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          busy
);

  localparam int unsigned LW = $clog2(DEPTH);

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e        state_q;
  logic [LW-1:0] idx_q;
  logic [31:0]   mem_q [DEPTH];
  logic          resp_valid_q;
  logic          resp_err_q;
  logic [31:0]   resp_rdata_q;

  logic [LW-1:0] widx;
  logic [1:0]    off;
  logic [AW-1:0] word_addr;
  logic          oob;
  logic          err_d;
  logic [31:0]   rd_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   rdata_d;
  logic [3:0]    wmask;
  logic [31:0]   wlane;
  logic          accept;
  logic          do_write;

  assign widx      = req_addr[LW+1:2];
  assign off       = req_addr[1:0];
  assign word_addr = req_addr >> 2;
  assign oob       = 64'(word_addr) >= 64'(DEPTH);
  assign accept    = req_valid && req_ready;
  assign do_write  = accept && req_we && !err_d;

  always_comb begin
    err_d = oob;
    case (req_funct3)
      3'b000:  ;
      3'b001:  err_d = err_d | off[0];
      3'b010:  err_d = err_d | (off != 2'b00);
      3'b100:  err_d = err_d | req_we;
      3'b101:  err_d = err_d | req_we | off[0];
      default: err_d = 1'b1;
    endcase
  end

  // Load path: pick the addressed byte/half out of the current word, then extend.
  always_comb begin
    rd_word = mem_q[widx];
    ld_byte = rd_word[{off, 3'b000} +: 8];
    ld_half = off[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_funct3)
      3'b000:  rdata_d = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  rdata_d = {24'b0, ld_byte};
      3'b001:  rdata_d = {{16{ld_half[15]}}, ld_half};
      3'b101:  rdata_d = {16'b0, ld_half};
      3'b010:  rdata_d = rd_word;
      default: rdata_d = '0;
    endcase
  end

  // Store data is replicated across lanes so the mask alone selects the target bytes.
  always_comb begin
    wmask = 4'b0000;
    wlane = req_wdata;
    case (req_funct3)
      3'b000: begin
        wmask = 4'b0001 << off;
        wlane = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        wmask = off[1] ? 4'b1100 : 4'b0011;
        wlane = {2{req_wdata[15:0]}};
      end
      3'b010:  wmask = 4'b1111;
      default: wmask = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= accept;
      if (accept) begin
        resp_err_q   <= err_d;
        resp_rdata_q <= (err_d || req_we) ? 32'b0 : rdata_d;
      end
      case (state_q)
        CLEAR: begin
          if (idx_q == LW'(DEPTH - 1)) state_q <= IDLE;
          else                         idx_q   <= idx_q + LW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[idx_q] <= '0;
      end else if (do_write) begin
        for (int l = 0; l < 4; l++) begin
          if (wmask[l]) mem_q[widx][8*l +: 8] <= wlane[8*l +: 8];
        end
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = ~req_ready;
  // A response still in flight when reset arrives is suppressed immediately.
  assign resp_valid = resp_valid_q & ~rst;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 Parameter DEPTH, default 256; memory size in 32-bit words; power of two, at least 4.
REQ-002 Parameter AW, default 32; byte-address width; AW SHALL be at least log2(DEPTH)+2.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset; synchronous and active-high.
REQ-005 Port req_valid, input, 1, request present.
REQ-006 Port req_ready, output, 1, block can accept a request this cycle.
REQ-007 Port req_we, input, 1: 1 = store, 0 = load.
REQ-008 Port req_funct3, input, 3, RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 Port req_addr, input, AW, byte address.
REQ-010 Port req_wdata, input, 32, store data, right-aligned: byte in [7:0], half in [15:0].
REQ-011 Port resp_valid, output, 1, one-cycle response pulse.
REQ-012 Port resp_rdata, output, 32, extended load result.
REQ-013 Port resp_err, output, 1, request rejected; valid only while resp_valid is high.
REQ-014 Port busy, output, 1, reset-clear sequence in progress.

Function
REQ-015 The block SHALL have two states: CLEAR and IDLE.
REQ-016 In CLEAR, each rising edge with rst low SHALL write zero to mem[idx]; at idx==DEPTH-1 it SHALL move to IDLE, otherwise it SHALL increment idx.
REQ-017 req_ready SHALL be high exactly when the state is IDLE; busy SHALL equal NOT req_ready.
REQ-018 A request is accepted on a rising edge where req_valid and req_ready are both high; the block SHALL accept one request per cycle, back-to-back.
REQ-019 For every accepted request, resp_valid SHALL pulse on the following cycle; in all other cycles resp_valid SHALL be 0.
REQ-020 Word index = req_addr[log2(DEPTH)+1:2]; byte offset = req_addr[1:0].
REQ-021 An error SHALL be flagged for any of the following:
  - funct3 is 011, 110 or 111;
  - store with funct3 100 or 101;
  - H/HU with addr[0]=1;
  - W with addr[1:0] != 0;
  - req_addr[AW-1:2] >= DEPTH.
REQ-022 An errored request SHALL NOT write memory; its response SHALL have resp_err=1 and resp_rdata=0.
REQ-023 A valid store SHALL write, at the acceptance edge, only the addressed byte lanes:
  - SB: lane = offset, data = wdata[7:0];
  - SH: lanes offset and offset+1, data = wdata[15:0];
  - SW: all four lanes.
  Other lanes SHALL be unchanged.
REQ-024 A valid store response SHALL have resp_err=0 and resp_rdata=0.
REQ-025 A load SHALL sample the word at the acceptance edge; the result is registered and appears with resp_valid one cycle later.
REQ-026 Load extraction SHALL be:
  - B/BU: byte at the offset, sign- or zero-extended;
  - H/HU: half at offset 0 or 2, sign- or zero-extended;
  - W: the full word.
REQ-027 A load accepted the cycle after a store to the same word SHALL return the post-store data.
REQ-028 resp_rdata and resp_err SHALL hold their values between responses.

Reset
REQ-029 On any rising edge with rst high, the block SHALL set state=CLEAR, idx=0, resp_valid=0, resp_err=0 and resp_rdata=0.
REQ-030 Reset SHALL apply mid-operation: an accepted request whose response is not yet issued SHALL be dropped, and any clear in progress SHALL restart from idx 0.
REQ-031 After rst falls, req_ready SHALL rise after exactly DEPTH rising edges; after that, every memory word reads zero.

Verification
REQ-032 Clear timing: DEPTH=8, rst high for 2 cycles then low.
  -> busy=1 and req_ready=0 for 8 edges, then req_ready=1.
  -> LW at 0x1C returns 0x00000000.
REQ-033 Store/load sizes: SW 0x80FF7F01 @0x10, then:
  - LB @0x10 -> 0x00000001;
  - LB @0x13 -> 0xFFFFFF80;
  - LBU @0x13 -> 0x00000080;
  - LH @0x12 -> 0xFFFF80FF;
  - LHU @0x12 -> 0x000080FF.
  Each response arrives exactly one cycle after acceptance.
REQ-034 Partial store: SW 0x11223344 @0x20, SB 0xAB @0x21, SH 0xBEEF @0x22, then LW @0x20 -> 0xBEEFAB44.
  Issue back-to-back with no idle cycles: 4 accepts produce 4 consecutive resp_valid pulses.
REQ-035 Errors:
  - LH @0x05 -> resp_err=1, rdata 0;
  - SW @0x06 -> resp_err=1 and memory unchanged;
  - funct3=011 -> resp_err=1;
  - LW @DEPTH*4 -> resp_err=1.
REQ-036 Reset mid-operation: accept LW, assert rst the next cycle.
  -> No resp_valid is produced.
  -> The clear restarts and the previously written word reads 0 afterwards.
REQ-037 Reset during CLEAR: assert rst at idx=5.
  -> req_ready rises only DEPTH edges after this rst falls.
